// File: rtl/icache_pkg.sv
// Shared types, geometry defaults and address helpers
// for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {IDLE, REFILL} state_t;

    localparam int DEF_LINE_ADDR_LEN = 3;
    localparam int DEF_SET_ADDR_LEN  = 4;

    function automatic logic [29:0] addr_word(
        input logic [29:0] a,
        input int          ll
    );
        return a & ((30'd1 << ll) - 30'd1);
    endfunction

    function automatic logic [29:0] addr_set(
        input logic [29:0] a,
        input int          ll,
        input int          sl
    );
        return (a >> ll) & ((30'd1 << sl) - 30'd1);
    endfunction

    function automatic logic [29:0] addr_tag(
        input logic [29:0] a,
        input int          ll,
        input int          sl
    );
        return a >> (ll + sl);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == '1) ? c : c + 32'd1;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Miss detection, line refill sequencing over the
// request/grant memory port, and deferred flush handling.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        hit,
    input  logic        flush,
    input  logic [31:2] addr,
    input  logic        mem_gnt,
    output state_t      state,
    output logic        start,
    output logic        mem_rd_req,
    output logic [31:2] mem_addr,
    output logic        fill_we,
    output logic        fill_valid,
    output logic        inval_all
);

    localparam int BW = (LINE_ADDR_LEN > 0) ? LINE_ADDR_LEN : 1;
    localparam logic [BW-1:0] LAST = BW'((1 << LINE_ADDR_LEN) - 1);
    localparam logic [29:0] WMASK = (30'd1 << LINE_ADDR_LEN) - 30'd1;

    state_t        state_d;
    logic [BW-1:0] beat;
    logic          flush_pend;
    logic          fill_last;
    logic          flush_eff;

    assign start     = (state == IDLE) && rd_req && !hit;
    assign fill_we   = (state == REFILL) && mem_gnt;
    assign fill_last = fill_we && (beat == LAST);
    assign flush_eff = flush_pend || flush;

    // A flush seen during refill must also veto the line being filled
    assign fill_valid = fill_last && !flush_eff;
    assign inval_all  = ((state == IDLE) && flush)
                     || (fill_last && flush_eff);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = REFILL;
            REFILL:  if (fill_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat       <= '0;
            mem_rd_req <= 1'b0;
            mem_addr   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (start) begin
                beat       <= '0;
                mem_rd_req <= 1'b1;
                mem_addr   <= addr & ~WMASK;
            end else if (fill_we) begin
                beat <= beat + BW'(1);
                if (fill_last) mem_rd_req <= 1'b0;
                else           mem_addr   <= mem_addr + 30'd1;
            end
            if (fill_last)
                flush_pend <= 1'b0;
            else if ((state == REFILL) && flush)
                flush_pend <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: tag/valid/data
// arrays, lookup, registered fetch output and statistics.
module icache_dm
    import icache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = DEF_SET_ADDR_LEN,
    parameter int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [31:2] addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        miss,
    input  logic        flush,
    output logic        mem_rd_req,
    output logic [31:2] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int SETS  = 1 << SET_ADDR_LEN;
    localparam int IW    = LINE_ADDR_LEN + SET_ADDR_LEN;
    localparam int WORDS = 1 << IW;

    logic [31:0]             data_arr [WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_arr  [SETS];
    logic [SETS-1:0]         valid;

    logic [TAG_ADDR_LEN-1:0] tag, fill_tag;
    logic [SET_ADDR_LEN-1:0] set_idx, fill_set;
    logic [IW-1:0]           rd_idx, wr_idx;

    state_t state;
    logic   hit, start, fill_we, fill_valid, inval_all;

    assign tag     = TAG_ADDR_LEN'(addr_tag(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign set_idx = SET_ADDR_LEN'(addr_set(addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign rd_idx  = IW'((addr_set(addr, LINE_ADDR_LEN, SET_ADDR_LEN)
                          << LINE_ADDR_LEN)
                         | addr_word(addr, LINE_ADDR_LEN));

    // The refill address already carries {tag, set, beat} of the line
    assign fill_tag = TAG_ADDR_LEN'(addr_tag(mem_addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign fill_set = SET_ADDR_LEN'(addr_set(mem_addr, LINE_ADDR_LEN, SET_ADDR_LEN));
    assign wr_idx   = IW'((addr_set(mem_addr, LINE_ADDR_LEN, SET_ADDR_LEN)
                           << LINE_ADDR_LEN)
                          | addr_word(mem_addr, LINE_ADDR_LEN));

    assign hit  = (state == IDLE) && rd_req && valid[set_idx]
               && (tag_arr[set_idx] == tag);
    assign miss = rd_req && !hit;

    icache_refill_fsm #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .hit        (hit),
        .flush      (flush),
        .addr       (addr),
        .mem_gnt    (mem_gnt),
        .state      (state),
        .start      (start),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .fill_we    (fill_we),
        .fill_valid (fill_valid),
        .inval_all  (inval_all)
    );

    always_ff @(posedge clk) begin
        if (fill_we)    data_arr[wr_idx]  <= mem_rd_data;
        if (fill_valid) tag_arr[fill_set] <= fill_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            rd_valid <= hit;
            if (hit) begin
                rd_data <= data_arr[rd_idx];
                hit_cnt <= sat_inc(hit_cnt);
            end
            if (start) miss_cnt <= sat_inc(miss_cnt);
            if (inval_all)       valid           <= '0;
            else if (fill_valid) valid[fill_set] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: fetch table with hand-computed
// hit/miss counts, plus flush and mid-refill reset sequences.
module tb_icache_dm;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic [31:2] addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        miss;
    logic        flush;
    logic        mem_rd_req;
    logic [31:2] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rd_data;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int          checks   = 0;
    int          failures = 0;
    int          beats    = 0;
    int          wait_left = 0;
    logic [29:0] cur_base = '0;

    icache_dm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .addr        (addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .miss        (miss),
        .flush       (flush),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rd_data (mem_rd_data),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] img(input logic [29:0] a);
        return {2'b10, a} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Backing memory: 0-3 wait cycles per beat, address checked every cycle
    initial begin
        mem_gnt     = 1'b0;
        mem_rd_data = '0;
        forever begin
            @(negedge clk);
            if (mem_gnt) begin
                beats++;
                mem_gnt   = 1'b0;
                wait_left = $urandom_range(0, 3);
            end
            if (!mem_rd_req) begin
                beats = 0;
            end else begin
                check("mem_addr", 32'(mem_addr), 32'(cur_base + 30'(beats)));
                if (wait_left == 0) begin
                    mem_gnt     = 1'b1;
                    mem_rd_data = img(mem_addr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    task automatic fetch(input string nm, input logic [29:0] a,
                         input bit exp_hit, input int fl_beat,
                         input bit fl_now, input int rst_beat,
                         input int exp_miss, input int exp_hits);
        int cyc = 0;
        bit fl_done = 1'b0;
        bit served = 1'b0;
        cur_base = a & ~30'h7;
        addr   = a;
        rd_req = 1'b1;
        flush  = fl_now;
        #1 check({nm, " miss"}, 32'(miss), 32'(!exp_hit));
        while (!served) begin
            @(negedge clk);
            #1;
            flush = 1'b0;
            cyc++;
            if (rd_valid) begin
                served = 1'b1;
            end else if (cyc > 200) begin
                checks++;
                failures++;
                $display("FAIL %s timeout actual=%0d cycles required<=200", nm, cyc);
                break;
            end else if (rst_beat >= 0 && beats == rst_beat) begin
                rst_n  = 1'b0;
                rd_req = 1'b0;
                #1;
                check({nm, " rst mem_rd_req"}, 32'(mem_rd_req), 32'd0);
                check({nm, " rst rd_valid"}, 32'(rd_valid), 32'd0);
                check({nm, " rst miss_cnt"}, miss_cnt, 32'd0);
                check({nm, " rst hit_cnt"}, hit_cnt, 32'd0);
                @(negedge clk);
                #1 rst_n = 1'b1;
                return;
            end else if (fl_beat >= 0 && !fl_done && beats == fl_beat) begin
                flush   = 1'b1;
                fl_done = 1'b1;
            end
        end
        if (served) begin
            check({nm, " rd_data"}, rd_data, img(a));
            check({nm, " hit"}, 32'(cyc == 1), 32'(exp_hit));
            check({nm, " miss_cnt"}, miss_cnt, 32'(exp_miss));
            check({nm, " hit_cnt"}, hit_cnt, 32'(exp_hits));
        end
        rd_req = 1'b0;
    endtask

    typedef struct {
        logic [29:0] a;
        bit          exp_hit;
        int          exp_miss;
        int          exp_hits;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{30'h000, 1'b0, 1, 1};
        vt[1]  = '{30'h001, 1'b1, 1, 2};
        vt[2]  = '{30'h002, 1'b1, 1, 3};
        vt[3]  = '{30'h003, 1'b1, 1, 4};
        vt[4]  = '{30'h004, 1'b1, 1, 5};
        vt[5]  = '{30'h005, 1'b1, 1, 6};
        vt[6]  = '{30'h006, 1'b1, 1, 7};
        vt[7]  = '{30'h007, 1'b1, 1, 8};
        vt[8]  = '{30'h000, 1'b1, 1, 9};
        vt[9]  = '{30'h080, 1'b0, 2, 10};
        vt[10] = '{30'h000, 1'b0, 3, 11};
        vt[11] = '{30'h080, 1'b0, 4, 12};
        vt[12] = '{30'h081, 1'b1, 4, 13};
        vt[13] = '{30'h013, 1'b0, 5, 14};
        vt[14] = '{30'h013, 1'b1, 5, 15};

        rst_n  = 1'b0;
        rd_req = 1'b0;
        addr   = '0;
        flush  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data", rd_data, 32'd0);
        check("reset mem_rd_req", 32'(mem_rd_req), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset hit_cnt", hit_cnt, 32'd0);
        check("reset miss_cnt", miss_cnt, 32'd0);
        check("reset miss", 32'(miss), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        for (int i = 0; i < 15; i++)
            fetch($sformatf("v%0d", i), vt[i].a, vt[i].exp_hit,
                  -1, 1'b0, -1, vt[i].exp_miss, vt[i].exp_hits);

        // Flush with a same-cycle hit: served, then the line is gone
        fetch("fl_idle_hit", 30'h013, 1'b1, -1, 1'b1, -1, 5, 16);
        fetch("fl_idle_miss", 30'h013, 1'b0, -1, 1'b0, -1, 6, 17);
        fetch("fl_idle_rehit", 30'h014, 1'b1, -1, 1'b0, -1, 6, 18);

        // Flush at beat 3: line stays invalid, held request refills again
        fetch("fl_refill", 30'h040, 1'b0, 3, 1'b0, -1, 8, 19);
        fetch("fl_refill_after", 30'h040, 1'b1, -1, 1'b0, -1, 8, 20);
        fetch("fl_refill_other", 30'h013, 1'b0, -1, 1'b0, -1, 9, 21);

        // Reset in the middle of a refill
        fetch("rst_refill", 30'h200, 1'b0, -1, 1'b0, 5, 0, 0);
        fetch("rst_after", 30'h200, 1'b0, -1, 1'b0, -1, 1, 1);
        fetch("rst_after_hit", 30'h207, 1'b1, -1, 1'b0, -1, 1, 2);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
